// File: rtl/puf_sig_slice_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : puf_sig_loader_pkg
// Description : Shared types, error codes and width helpers for the PUF
//               signature slice loader and its slot bank.
// Revision    : 1.0 - initial release
// ============================================================================
package puf_sig_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BUSY     = 2'd1;
    localparam logic [1:0] ERR_NOT_FULL = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    // Number of slices that make up one signature
    function automatic int calc_ns(input int sig_w, input int slice_w);
        return sig_w / slice_w;
    endfunction

    // Slice counter width: must be able to hold the value NS
    function automatic int calc_cw(input int ns);
        return $clog2(ns + 1);
    endfunction

    // Index width for n entries, never narrower than one bit
    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/puf_sig_slot_bank.sv
`default_nettype none
// ============================================================================
// Module      : puf_sig_slot_bank
// Description : NUM_SLOTS x SIG_W signature storage organised as slices.
//               Slice 0 is the most significant slice of a signature.
//               One slice write port, one slice read port, one full-width
//               read of the same slot.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_sig_slot_bank
    import puf_sig_loader_pkg::*;
#(
    parameter  int SIG_W     = 256,
    parameter  int SLICE_W   = 16,
    parameter  int NUM_SLOTS = 4,
    localparam int NS        = calc_ns(SIG_W, SLICE_W),
    localparam int SW        = calc_idx_w(NUM_SLOTS),
    localparam int IW        = calc_idx_w(NS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [SW-1:0]      wr_slot_i,
    input  logic [IW-1:0]      wr_idx_i,
    input  logic [SLICE_W-1:0] wr_data_i,
    input  logic [SW-1:0]      rd_slot_i,
    input  logic [IW-1:0]      rd_idx_i,
    output logic [SLICE_W-1:0] rd_data_o,
    output logic [SIG_W-1:0]   rd_sig_o
);

    // Arrays are padded to a power of two so every index value is in range
    localparam int DEPTH   = 1 << SW;
    localparam int ENTRIES = 1 << IW;

    logic [SLICE_W-1:0] mem_q [DEPTH][ENTRIES];

    // Slice storage: cleared on reset, one slice written per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                for (int k = 0; k < ENTRIES; k++) begin
                    mem_q[s][k] <= '0;
                end
            end
        end else if (wr_en_i) begin
            mem_q[wr_slot_i][wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_slot_i][rd_idx_i];

    // Slice k lands at the k-th slice position counting down from the MSB
    for (genvar k = 0; k < NS; k++) begin : g_pack
        assign rd_sig_o[SIG_W-1-k*SLICE_W -: SLICE_W] = mem_q[rd_slot_i][k];
    end

endmodule
`default_nettype wire

// File: rtl/puf_sig_slice_loader.sv
`default_nettype none
// ============================================================================
// Module      : puf_sig_slice_loader
// Description : Assembles SIG_W-bit PUF signatures from SLICE_W-bit GPIO
//               slices into one of NUM_SLOTS slots, reads completed slots
//               back slice by slice, and reports abort/timeout/misuse errors.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_sig_slice_loader
    import puf_sig_loader_pkg::*;
#(
    parameter  int SIG_W     = 256,
    parameter  int SLICE_W   = 16,
    parameter  int NUM_SLOTS = 4,
    parameter  int TIMEOUT   = 1024,
    localparam int NS        = calc_ns(SIG_W, SLICE_W),
    localparam int SW        = calc_idx_w(NUM_SLOTS),
    localparam int CW        = calc_cw(NS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [SW-1:0]        slot_sel,
    input  logic                 abort,
    input  logic                 slice_wr,
    input  logic [SLICE_W-1:0]   slice_in,
    input  logic                 slice_rd,
    output logic [SLICE_W-1:0]   slice_out,
    output logic                 slice_out_valid,
    output logic [SIG_W-1:0]     sig_out,
    output logic                 sig_valid,
    output logic [SW-1:0]        sig_slot,
    output logic [NUM_SLOTS-1:0] slot_full,
    output logic                 busy,
    output logic [CW-1:0]        slice_cnt,
    output logic                 err,
    output logic [1:0]           err_code
);

    localparam int IW    = calc_idx_w(NS);
    localparam int TW    = $clog2(TIMEOUT);
    localparam int DEPTH = 1 << SW;
    localparam logic [SIG_W-1:0] LOW_MASK = SIG_W'({SLICE_W{1'b1}});

    if (((SIG_W % SLICE_W) != 0) || (NUM_SLOTS < 1) || (TIMEOUT < 2)) begin : g_param_check
        $error("puf_sig_slice_loader: SIG_W must be a multiple of SLICE_W, NUM_SLOTS>=1, TIMEOUT>=2");
    end

    state_t               state_q, state_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [DEPTH-1:0]     full_q, full_d;
    logic [SLICE_W-1:0]   slice_out_q, slice_out_d;
    logic                 slice_out_valid_q, slice_out_valid_d;
    logic [SIG_W-1:0]     sig_out_q, sig_out_d;
    logic                 sig_valid_q, sig_valid_d;
    logic [SW-1:0]        sig_slot_q, sig_slot_d;
    logic                 busy_q;
    logic                 err_q, err_d;
    logic [1:0]           err_code_q, err_code_d;

    logic                 w_bank_wr;
    logic [IW-1:0]        w_idx;
    logic [SLICE_W-1:0]   w_rd_slice;
    logic [SIG_W-1:0]     w_rd_sig;
    logic [SIG_W-1:0]     w_merged;
    logic                 w_last;
    logic                 w_tmo;

    assign w_idx  = cnt_q[IW-1:0];
    assign w_last = (cnt_q == CW'(NS - 1));
    assign w_tmo  = (timer_q == TW'(TIMEOUT - 1));
    // The final slice is the least significant one; splice it in so the
    // completed signature can be published in the same cycle it arrives.
    assign w_merged = (w_rd_sig & ~LOW_MASK) | SIG_W'(slice_in);

    puf_sig_slot_bank #(
        .SIG_W     (SIG_W),
        .SLICE_W   (SLICE_W),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (w_bank_wr),
        .wr_slot_i (slot_q),
        .wr_idx_i  (w_idx),
        .wr_data_i (slice_in),
        .rd_slot_i (slot_q),
        .rd_idx_i  (w_idx),
        .rd_data_o (w_rd_slice),
        .rd_sig_o  (w_rd_sig)
    );

    // Next-state and output decode for the transfer controller
    always_comb begin
        state_d           = state_q;
        slot_d            = slot_q;
        cnt_d             = cnt_q;
        timer_d           = timer_q;
        full_d            = full_q;
        slice_out_d       = slice_out_q;
        slice_out_valid_d = 1'b0;
        sig_out_d         = sig_out_q;
        sig_valid_d       = 1'b0;
        sig_slot_d        = sig_slot_q;
        err_d             = 1'b0;
        err_code_d        = err_code_q;
        w_bank_wr         = 1'b0;

        if (start && (state_q != ST_IDLE)) begin
            err_d      = 1'b1;
            err_code_d = ERR_BUSY;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mode) begin
                        state_d          = ST_LOAD;
                        slot_d           = slot_sel;
                        full_d[slot_sel] = 1'b0;
                        cnt_d            = '0;
                        timer_d          = '0;
                    end else if (full_q[slot_sel]) begin
                        state_d = ST_READ;
                        slot_d  = slot_sel;
                        cnt_d   = '0;
                        timer_d = '0;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_NOT_FULL;
                    end
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (slice_wr) begin
                    w_bank_wr = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                    timer_d   = '0;
                    if (w_last) begin
                        state_d        = ST_DONE;
                        full_d[slot_q] = 1'b1;
                        sig_out_d      = w_merged;
                        sig_slot_d     = slot_q;
                        sig_valid_d    = 1'b1;
                    end
                end else if (w_tmo) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (slice_rd) begin
                    slice_out_d       = w_rd_slice;
                    slice_out_valid_d = 1'b1;
                    cnt_d             = cnt_q + CW'(1);
                    timer_d           = '0;
                    if (w_last) begin
                        state_d = ST_IDLE;
                    end
                end else if (w_tmo) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            slot_q            <= '0;
            cnt_q             <= '0;
            timer_q           <= '0;
            full_q            <= '0;
            slice_out_q       <= '0;
            slice_out_valid_q <= 1'b0;
            sig_out_q         <= '0;
            sig_valid_q       <= 1'b0;
            sig_slot_q        <= '0;
            busy_q            <= 1'b0;
            err_q             <= 1'b0;
            err_code_q        <= ERR_NONE;
        end else begin
            state_q           <= state_d;
            slot_q            <= slot_d;
            cnt_q             <= cnt_d;
            timer_q           <= timer_d;
            full_q            <= full_d;
            slice_out_q       <= slice_out_d;
            slice_out_valid_q <= slice_out_valid_d;
            sig_out_q         <= sig_out_d;
            sig_valid_q       <= sig_valid_d;
            sig_slot_q        <= sig_slot_d;
            busy_q            <= (state_d != ST_IDLE);
            err_q             <= err_d;
            err_code_q        <= err_code_d;
        end
    end

    assign slice_out       = slice_out_q;
    assign slice_out_valid = slice_out_valid_q;
    assign sig_out         = sig_out_q;
    assign sig_valid       = sig_valid_q;
    assign sig_slot        = sig_slot_q;
    assign slot_full       = full_q[NUM_SLOTS-1:0];
    assign busy            = busy_q;
    assign slice_cnt       = cnt_q;
    assign err             = err_q;
    assign err_code        = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_puf_sig_slice_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_puf_sig_slice_loader
// Description : Scoreboard bench for puf_sig_slice_loader: randomized
//               loads/readbacks against a slot-array reference model, plus a
//               small 128/32/1-slot instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_puf_sig_slice_loader;

    localparam int SIG_W     = 256;
    localparam int SLICE_W   = 16;
    localparam int NUM_SLOTS = 4;
    localparam int TIMEOUT   = 24;
    localparam int NS        = SIG_W / SLICE_W;
    localparam int SW        = 2;
    localparam int CW        = $clog2(NS + 1);

    localparam int SIG_W2    = 128;
    localparam int SLICE_W2  = 32;
    localparam int NS2       = SIG_W2 / SLICE_W2;
    localparam int CW2       = $clog2(NS2 + 1);

    localparam int E_BUSY    = 1;
    localparam int E_NFULL   = 2;
    localparam int E_TMO     = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 start, mode, abort, slice_wr, slice_rd;
    logic [SW-1:0]        slot_sel;
    logic [SLICE_W-1:0]   slice_in, slice_out;
    logic                 slice_out_valid, sig_valid, busy, err;
    logic [SIG_W-1:0]     sig_out;
    logic [SW-1:0]        sig_slot;
    logic [NUM_SLOTS-1:0] slot_full;
    logic [CW-1:0]        slice_cnt;
    logic [1:0]           err_code;

    logic                 start2, mode2, abort2, slice_wr2, slice_rd2;
    logic [0:0]           slot_sel2, sig_slot2, slot_full2;
    logic [SLICE_W2-1:0]  slice_in2, slice_out2;
    logic                 slice_out_valid2, sig_valid2, busy2, err2;
    logic [SIG_W2-1:0]    sig_out2;
    logic [CW2-1:0]       slice_cnt2;
    logic [1:0]           err_code2;

    puf_sig_slice_loader #(
        .SIG_W(SIG_W), .SLICE_W(SLICE_W), .NUM_SLOTS(NUM_SLOTS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .slot_sel(slot_sel),
        .abort(abort), .slice_wr(slice_wr), .slice_in(slice_in), .slice_rd(slice_rd),
        .slice_out(slice_out), .slice_out_valid(slice_out_valid), .sig_out(sig_out),
        .sig_valid(sig_valid), .sig_slot(sig_slot), .slot_full(slot_full), .busy(busy),
        .slice_cnt(slice_cnt), .err(err), .err_code(err_code)
    );

    puf_sig_slice_loader #(
        .SIG_W(SIG_W2), .SLICE_W(SLICE_W2), .NUM_SLOTS(1), .TIMEOUT(TIMEOUT)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode2), .slot_sel(slot_sel2),
        .abort(abort2), .slice_wr(slice_wr2), .slice_in(slice_in2), .slice_rd(slice_rd2),
        .slice_out(slice_out2), .slice_out_valid(slice_out_valid2), .sig_out(sig_out2),
        .sig_valid(sig_valid2), .sig_slot(sig_slot2), .slot_full(slot_full2), .busy(busy2),
        .slice_cnt(slice_cnt2), .err(err2), .err_code(err_code2)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [SIG_W-1:0] data;
        int               slot;
        int               at;
    } exp_t;

    exp_t q_sig[$];
    exp_t q_slice[$];
    exp_t q_err[$];

    // Reference model: slot contents as a plain slice array, slice 0 first
    logic [SLICE_W-1:0] m_mem [NUM_SLOTS][NS];
    bit                 m_full [NUM_SLOTS];

    function automatic logic [SIG_W-1:0] model_sig(input int s);
        logic [SIG_W-1:0] v = '0;
        for (int k = 0; k < NS; k++) v = (v << SLICE_W) | SIG_W'(m_mem[s][k]);
        return v;
    endfunction

    function automatic logic [NUM_SLOTS-1:0] model_full();
        logic [NUM_SLOTS-1:0] v = '0;
        for (int s = 0; s < NUM_SLOTS; s++) v[s] = m_full[s];
        return v;
    endfunction

    task automatic chk(input string name, input logic [SIG_W-1:0] got, input logic [SIG_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input int kind, input logic [SIG_W-1:0] d, input int s, input int at);
        exp_t e;
        e.data = d; e.slot = s; e.at = at;
        if (kind == 0) q_sig.push_back(e);
        else if (kind == 1) q_slice.push_back(e);
        else q_err.push_back(e);
    endtask

    task automatic report_missing(input string name, input int at);
        n_checks++;
        n_err++;
        $display("FAIL %s: no output at cycle %0d expected by cycle %0d", name, cyc, at);
    endtask

    task automatic report_unexpected(input string name, input logic [SIG_W-1:0] got);
        n_checks++;
        n_err++;
        $display("FAIL %s: unexpected output %0h expected none (cycle %0d)", name, got, cyc);
    endtask

    // Monitor: every output pulse is matched against the scoreboard queues
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sig_valid) begin
                if (q_sig.size() == 0) report_unexpected("sig_valid", sig_out);
                else begin
                    e = q_sig.pop_front();
                    chk("sig_out", sig_out, e.data);
                    chk("sig_slot", SIG_W'(sig_slot), SIG_W'(e.slot));
                    chk("sig_cycle", SIG_W'(cyc), SIG_W'(e.at));
                end
            end
            if (slice_out_valid) begin
                if (q_slice.size() == 0) report_unexpected("slice_out_valid", SIG_W'(slice_out));
                else begin
                    e = q_slice.pop_front();
                    chk("slice_out", SIG_W'(slice_out), e.data);
                    chk("slice_cycle", SIG_W'(cyc), SIG_W'(e.at));
                end
            end
            if (err) begin
                if (q_err.size() == 0) report_unexpected("err", SIG_W'(err_code));
                else begin
                    e = q_err.pop_front();
                    chk("err_code", SIG_W'(err_code), e.data);
                    chk("err_cycle", SIG_W'(cyc), SIG_W'(e.at));
                end
            end
            while (q_sig.size() > 0 && q_sig[0].at < cyc) begin
                report_missing("sig_valid", q_sig[0].at); void'(q_sig.pop_front());
            end
            while (q_slice.size() > 0 && q_slice[0].at < cyc) begin
                report_missing("slice_out_valid", q_slice[0].at); void'(q_slice.pop_front());
            end
            while (q_err.size() > 0 && q_err[0].at < cyc) begin
                report_missing("err", q_err[0].at); void'(q_err.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load slot s with n slices; optionally abort together with slice n+1,
    // optionally pulse start alongside slice busy_k.
    task automatic do_load(input int s, input bit counting, input int n, input bit abort_end,
                           input int busy_k, input int max_gap);
        logic [SLICE_W-1:0] d;
        start = 1'b1; mode = 1'b1; slot_sel = SW'(s);
        step();
        start = 1'b0;
        m_full[s] = 1'b0;
        chk("busy_after_start", SIG_W'(busy), SIG_W'(1));
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(max_gap, 0)) step();
            d = counting ? SLICE_W'(k + 1) : SLICE_W'($urandom);
            slice_wr = 1'b1; slice_in = d;
            if (k == busy_k) begin
                start = 1'b1; mode = 1'($urandom); slot_sel = SW'($urandom);
                push_exp(2, SIG_W'(E_BUSY), 0, cyc + 1);
            end
            m_mem[s][k] = d;
            if (k == NS - 1) begin
                m_full[s] = 1'b1;
                push_exp(0, model_sig(s), s, cyc + 1);
            end
            step();
            slice_wr = 1'b0; start = 1'b0;
            chk("slice_cnt_load", SIG_W'(slice_cnt), SIG_W'(k + 1));
        end
        if (abort_end) begin
            slice_wr = 1'b1; slice_in = SLICE_W'($urandom); abort = 1'b1;
            step();
            slice_wr = 1'b0; abort = 1'b0;
            chk("busy_after_abort", SIG_W'(busy), SIG_W'(0));
            chk("slot_full_after_abort", SIG_W'(slot_full), SIG_W'(model_full()));
        end else if (n == NS) begin
            chk("busy_in_done", SIG_W'(busy), SIG_W'(1));
            chk("slot_full_after_load", SIG_W'(slot_full), SIG_W'(model_full()));
            step();
            chk("busy_after_done", SIG_W'(busy), SIG_W'(0));
        end
    endtask

    task automatic do_read(input int s, input int max_gap);
        start = 1'b1; mode = 1'b0; slot_sel = SW'(s);
        if (!m_full[s]) begin
            push_exp(2, SIG_W'(E_NFULL), 0, cyc + 1);
            step();
            start = 1'b0;
            chk("busy_bad_read", SIG_W'(busy), SIG_W'(0));
            return;
        end
        step();
        start = 1'b0;
        chk("busy_read", SIG_W'(busy), SIG_W'(1));
        for (int k = 0; k < NS; k++) begin
            repeat ($urandom_range(max_gap, 0)) step();
            slice_rd = 1'b1;
            push_exp(1, SIG_W'(m_mem[s][k]), s, cyc + 1);
            step();
            slice_rd = 1'b0;
            chk("slice_cnt_read", SIG_W'(slice_cnt), SIG_W'(k + 1));
        end
        chk("busy_after_read", SIG_W'(busy), SIG_W'(0));
        chk("slot_full_after_read", SIG_W'(slot_full), SIG_W'(model_full()));
    endtask

    task automatic clear_model();
        for (int s = 0; s < NUM_SLOTS; s++) begin
            m_full[s] = 1'b0;
            for (int k = 0; k < NS; k++) m_mem[s][k] = '0;
        end
    endtask

    task automatic check_reset_values();
        chk("rst_slice_out", SIG_W'(slice_out), '0);
        chk("rst_slice_out_valid", SIG_W'(slice_out_valid), '0);
        chk("rst_sig_out", sig_out, '0);
        chk("rst_sig_valid", SIG_W'(sig_valid), '0);
        chk("rst_sig_slot", SIG_W'(sig_slot), '0);
        chk("rst_slot_full", SIG_W'(slot_full), '0);
        chk("rst_busy", SIG_W'(busy), '0);
        chk("rst_slice_cnt", SIG_W'(slice_cnt), '0);
        chk("rst_err", SIG_W'(err), '0);
        chk("rst_err_code", SIG_W'(err_code), '0);
    endtask

    initial begin
        logic [SIG_W2-1:0] exp2;
        rst = 1'b1;
        start = 0; mode = 0; abort = 0; slice_wr = 0; slice_rd = 0;
        slot_sel = '0; slice_in = '0;
        start2 = 0; mode2 = 0; abort2 = 0; slice_wr2 = 0; slice_rd2 = 0;
        slot_sel2 = '0; slice_in2 = '0;
        clear_model();
        repeat (3) step();
        check_reset_values();
        rst = 1'b0;
        step();

        // Counting pattern into slot 0, then read it back
        do_load(0, 1'b1, NS, 1'b0, -1, 0);
        chk("sig_out_counting", sig_out, 256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010);
        do_read(0, 0);

        // Readback of an empty slot
        do_read(2, 0);

        // Abort alongside the sixth slice, then a timeout after five slices
        do_load(1, 1'b0, 5, 1'b1, -1, 0);
        do_load(1, 1'b0, 5, 1'b0, -1, 0);
        push_exp(2, SIG_W'(E_TMO), 0, cyc + TIMEOUT);
        repeat (TIMEOUT + 1) step();
        chk("busy_after_timeout", SIG_W'(busy), SIG_W'(0));
        chk("slot_full_after_timeout", SIG_W'(slot_full), SIG_W'(model_full()));

        // start while loading is flagged but the load still completes
        do_load(2, 1'b0, NS, 1'b0, 3, 2);
        do_read(2, 2);

        // Random mix of loads and readbacks with gaps
        repeat (10) begin
            if ($urandom_range(1, 0) == 1) do_load($urandom_range(NUM_SLOTS - 1, 0), 1'b0, NS, 1'b0, -1, 3);
            else do_read($urandom_range(NUM_SLOTS - 1, 0), 3);
        end

        // Reset in the middle of loading slot 3 while slot 0 is full
        do_load(0, 1'b0, NS, 1'b0, -1, 1);
        do_load(3, 1'b0, 6, 1'b0, -1, 0);
        rst = 1'b1;
        step();
        check_reset_values();
        rst = 1'b0;
        clear_model();
        step();
        do_read(0, 0);

        // 128/32 single-slot instance: counting load then readback
        start2 = 1'b1; mode2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int k = 0; k < NS2; k++) begin
            slice_wr2 = 1'b1; slice_in2 = SLICE_W2'(k + 1);
            step();
        end
        slice_wr2 = 1'b0;
        exp2 = 128'h00000001_00000002_00000003_00000004;
        chk("sweep_sig_valid", SIG_W'(sig_valid2), SIG_W'(1));
        chk("sweep_sig_out", SIG_W'(sig_out2), SIG_W'(exp2));
        chk("sweep_slot_full", SIG_W'(slot_full2), SIG_W'(1));
        step();
        chk("sweep_sig_valid_pulse", SIG_W'(sig_valid2), SIG_W'(0));
        chk("sweep_busy", SIG_W'(busy2), SIG_W'(0));
        start2 = 1'b1; mode2 = 1'b0;
        step();
        start2 = 1'b0;
        for (int k = 0; k < NS2; k++) begin
            slice_rd2 = 1'b1;
            step();
            slice_rd2 = 1'b0;
            chk("sweep_slice_out", SIG_W'({slice_out_valid2, slice_out2}), SIG_W'({1'b1, SLICE_W2'(k + 1)}));
        end
        chk("sweep_busy_after_read", SIG_W'(busy2), SIG_W'(0));

        repeat (4) step();
        chk("scoreboard_drained", SIG_W'(q_sig.size() + q_slice.size() + q_err.size()), '0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
